// File: rtl/tt_sweep_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tt_sweep_pkg : shared types and helpers for the truth-table sweep sequencer |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
package tt_sweep_pkg;

  localparam int TT_W  = 8;
  localparam int ROW_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Wolfram ordering puts row 000 in the MSB of the table.
  function automatic logic [ROW_W-1:0] row_to_bit(input logic [ROW_W-1:0] r);
    return ROW_W'(TT_W - 1) - r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tt_vote3.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tt_vote3 : two-deep capture history plus 2-of-3 majority with the live bit |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tt_vote3 (
  input  logic clk,
  input  logic rst_n,
  input  logic shift,
  input  logic din,
  output logic maj
);

  logic [1:0] hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
    end else if (shift) begin
      hist <= {hist[0], din};
    end
  end

  // The third vote is the bit being captured on this edge, so no clear is needed between rows.
  assign maj = (hist[1] & hist[0]) | (hist[1] & din) | (hist[0] & din);

endmodule
`default_nettype wire

// File: rtl/tt_sweep_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tt_sweep_ctrl : sweeps a 3-input cell over all rows and checks its table;  |
// |                 TT_SAMPLE_VOTE_EN enables 3-capture majority sampling.     |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
module tt_sweep_ctrl
  import tt_sweep_pkg::*;
#(
  parameter int unsigned      SETTLE_CYCLES = 4,
  parameter logic [TT_W-1:0]  EXPECTED      = 8'hC4,
  parameter int unsigned      CNT_W         = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ROW_W-1:0]  dut_in,
  input  logic              dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [TT_W-1:0]   measured,
  output logic [TT_W-1:0]   mismatch
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ROW_W-1:0] ROW_LAST    = '1;

  if (SETTLE_CYCLES == 0 || SETTLE_CYCLES > 255 ||
      SETTLE_CYCLES >= (64'd1 << CNT_W)) begin : g_bad_settle
    $error("tt_sweep_ctrl: SETTLE_CYCLES out of range for CNT_W");
  end

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [ROW_W-1:0]  idx;

  logic accept;
  logic kill;
  logic commit;
  logic next_row;
  logic finish;
  logic sample_last;
  logic sample_bit;
  logic sample_go;

`ifdef TT_SAMPLE_VOTE_EN
  logic [1:0] vcnt;
  logic       vote_bit;

  tt_vote3 u_vote (
    .clk   (clk),
    .rst_n (rst_n),
    .shift (sample_go),
    .din   (dut_out),
    .maj   (vote_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vcnt <= '0;
    end else if (sample_go && !sample_last) begin
      vcnt <= vcnt + 2'd1;
    end else begin
      vcnt <= '0;
    end
  end

  assign sample_last = (vcnt == 2'd2);
  assign sample_bit  = vote_bit;
`else
  assign sample_last = 1'b1;
  assign sample_bit  = dut_out;
`endif

  assign sample_go = (state == SAMPLE) && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    kill      = 1'b0;
    commit    = 1'b0;
    next_row  = 1'b0;
    finish    = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        // abort has priority so a simultaneous start is dropped.
        if (start && !abort) begin
          state_nxt = APPLY;
          accept    = 1'b1;
        end
      end
      APPLY: begin
        busy = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
          kill      = 1'b1;
        end else if (cnt == SETTLE_LAST) begin
          state_nxt = SAMPLE;
        end
      end
      SAMPLE: begin
        busy = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
          kill      = 1'b1;
        end else if (sample_last) begin
          commit = 1'b1;
          if (idx == ROW_LAST) begin
            state_nxt = DONE;
            finish    = 1'b1;
          end else begin
            state_nxt = APPLY;
            next_row  = 1'b1;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      idx      <= '0;
      dut_in   <= '0;
      measured <= '0;
      done     <= 1'b0;
      pass     <= 1'b0;
      mismatch <= '0;
    end else begin
      done <= (state == DONE);
      // Verdict outputs only move at the end of a completed sweep.
      if (state == DONE) begin
        pass     <= (measured == EXPECTED);
        mismatch <= measured ^ EXPECTED;
      end

      if (accept || next_row) begin
        cnt <= '0;
      end else if (state == APPLY) begin
        cnt <= cnt + CNT_W'(1);
      end

      if (accept) begin
        idx <= '0;
      end else if (next_row) begin
        idx <= idx + ROW_W'(1);
      end

      if (next_row) begin
        dut_in <= idx + ROW_W'(1);
      end else if (accept || kill || finish) begin
        dut_in <= '0;
      end

      if (accept) begin
        measured <= '0;
      end else if (commit) begin
        measured[row_to_bit(idx)] <= sample_bit;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/tt_sweep_ctrl.md
Name: tt_sweep_ctrl

Overview:
- Sequencer for a 3-input, 1-output combinational logic cell (Wolfram-numbered truth-table gate).
- Steps the cell through all 8 input combinations and waits a programmable settle time for each.
- Samples the cell output for each combination, assembles the measured 8-bit truth table, and compares it with an expected table.
- Sits between the test/characterisation harness and one logic-cell instance.

Parameters:
- SETTLE_CYCLES, 4: cycles each input combination is held before sampling; legal range 1..255.
- EXPECTED, 8'hC4: expected truth table in Wolfram order.
- CNT_W, 8: settle-counter width; must hold SETTLE_CYCLES.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  reset, active-low.
- start  input  1  request a sweep; sampled only in IDLE.
- abort  input  1  cancel the sweep in progress.
- dut_in  output  3  drives {in1,in2,in3} of the cell.
- dut_out  input  1  cell output.
- busy  output  1  high from APPLY through SAMPLE.
- done  output  1  one-cycle pulse when a sweep completes.
- pass  output  1  measured == EXPECTED; valid when done and held afterwards.
- measured  output  8  captured truth table.
- mismatch  output  8  measured XOR EXPECTED.

Behaviour:
- Clocking and reset: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: dut_in=0, busy=0, done=0, pass=0, measured=0, mismatch=0; FSM in IDLE.
- Bit mapping (Wolfram order): row r={in1,in2,in3}; measured[7-r] = dut_out. Row 000 is the MSB, so EXPECTED=8'hC4 means rows 000, 001 and 101 give 1.
- FSM states: IDLE, APPLY, SAMPLE, DONE.
- IDLE:
  - dut_in=000, busy=0.
  - start=1 → APPLY next cycle; row index=0; settle counter=0; measured cleared to 0.
- APPLY:
  - dut_in = row index, registered.
  - Counter increments each cycle.
  - After exactly SETTLE_CYCLES cycles in APPLY → SAMPLE.
- SAMPLE (1 cycle):
  - Registers dut_out into measured[7-idx].
  - idx==7 → DONE; otherwise idx+1 → APPLY with counter reset.
  - dut_in holds the current row during SAMPLE.
- DONE (1 cycle):
  - done=1.
  - pass and mismatch are updated from the final measured value. pass and mismatch update only here and hold until the next DONE or reset.
  - Next state is IDLE.
- Latency: done is high 8*(SETTLE_CYCLES+1)+1 cycles after the edge that accepts start; 41 cycles with defaults.
- start while busy or in DONE is ignored; there is no queueing.
- abort:
  - abort=1 in APPLY or SAMPLE → IDLE next cycle.
  - No done pulse; pass and mismatch keep their previous values; measured holds the partial result.
  - abort in IDLE has no effect.
  - abort and start together in IDLE: abort wins and no sweep starts.
- Reset mid-sweep: asynchronous return to reset values; no done.
- dut_out is treated as synchronous to clk; the settle time covers cell propagation delay.

Optional Feature:
- Macro: TT_SAMPLE_VOTE_EN.
- Defined:
  - SAMPLE lasts 3 cycles, capturing dut_out in each.
  - The stored bit is the majority of the 3 captures.
  - Per-row time becomes SETTLE_CYCLES+3; latency becomes 8*(SETTLE_CYCLES+3)+1 (57 with defaults).
  - abort during any of the 3 vote cycles behaves as above.
- Undefined: single-cycle SAMPLE as specified above.

Decomposition:
- Package tt_sweep_pkg:
  - state enum (IDLE, APPLY, SAMPLE, DONE).
  - TT_W=8, ROW_W=3.
  - function row_to_bit(r) = 7-r.
- One sub-module, tt_vote3: 3-sample shift register plus majority. Instantiated only under TT_SAMPLE_VOTE_EN.

Test Plan:
1. Nominal sweep:
   - Stimulus: cell model implementing 0xC4 (out = (~in1 & ~in2) | (in1 & ~in2 & in3)); start pulse.
   - Required: dut_in steps 0..7, each held 5 cycles; done at cycle 41; measured=8'hC4, pass=1, mismatch=0.
2. Wrong cell:
   - Stimulus: cell model = 0xC5 (row 111 returns 1).
   - Required: measured=8'hC5, pass=0, mismatch=8'h01.
3. Abort:
   - Stimulus: abort during row 3 APPLY.
   - Required: IDLE next cycle, dut_in=0, busy=0, no done; pass/mismatch retain prior values.
4. start while busy:
   - Stimulus: start during a sweep.
   - Required: exactly one done; total latency unchanged.
5. Async reset:
   - Stimulus: rst_n low mid-SAMPLE, between clock edges.
   - Required: all outputs 0 immediately.
   - Follow-up: after release, a new start gives correct 8'hC4.
6. Majority vote (TT_SAMPLE_VOTE_EN defined):
   - Stimulus: cell output glitches to 1 for one of the 3 sample cycles on row 010.
   - Required: measured=8'hC4, pass=1, done at cycle 57.
